multi_timestamp_capture: RTL and testbench
==========================================

# multi_timestamp_capture

Multi-channel successor to the single-channel timer: one free-running timestamp counter shared by CHANNELS threshold-detector inputs. The block captures the arrival time of the first rising edge on each channel within a configurable coincidence window. It then streams the completed set, one channel per handshake, to the downstream TDOA / localisation logic. Detect inputs may come from a different clock domain's logic and may stay high for many cycles; only rising edges count.

## Interface
- CHANNELS, 4: number of detect inputs; legal range 2..16.
- TS_WIDTH, 32: timestamp counter and output width.
- WINDOW, 50000: coincidence window length in clk cycles, measured from the first edge; must be ≥1 and < 2^TS_WIDTH.
- clk  in  1  sole clock.
- rst  in  1  synchronous, active-high reset.
- detect  in  CHANNELS  level detect flags from the threshold stage; bit i is channel i.
- ts_valid  out  1  output word valid.
- ts_ready  in  1  downstream accepts the word when high together with ts_valid.
- ts_value  out  TS_WIDTH  captured timestamp for ts_channel.
- ts_channel  out  CH_W  channel index, where CH_W = max(1, $clog2(CHANNELS)).
- ts_hit  out  1  1 = the channel fired inside the window; 0 = missed, and ts_value is 0.
- ts_last  out  1  high on the word for channel CHANNELS-1.
- busy  out  1  high in COLLECT or OUTPUT.

## Operation
- Counter: cnt resets to 0, increments every cycle in all states, and wraps modulo 2^TS_WIDTH.
- Edge detect: prev[i] is registered every cycle in every state. edge[i] = detect[i] & ~prev[i], evaluated combinationally in the current cycle. A level held high across state changes never produces a second edge.
- The capture value is cnt as seen in the edge cycle, before the increment.
- IDLE:
  - Capture regs and hit flags are cleared.
  - Any edge moves the block to COLLECT.
  - Every channel with an edge in that cycle is captured. t0 = cnt and wcnt = 1 are loaded.
- COLLECT:
  - An edge on a channel whose hit flag is 0 captures cnt and sets the flag.
  - Later edges on a channel that is already hit are ignored.
  - wcnt increments each cycle.
  - Leave for OUTPUT when all hit flags are 1, or when wcnt == WINDOW. The last capturable cycle is t0 + WINDOW - 1.
  - If both conditions are true in the same cycle, the transition happens once, and edges in that cycle are still captured.
- OUTPUT:
  - ts_valid = 1 and ts_channel starts at 0.
  - On ts_valid & ts_ready, ts_channel advances. The handshake on CHANNELS-1 (ts_last) returns the block to IDLE on the next cycle.
  - ts_value, ts_hit and ts_channel hold stable while ts_valid & ~ts_ready.
  - Edges in OUTPUT are dropped, but prev still tracks detect.
- Reset at any point: IDLE, all flags, capture regs, cnt and prev are cleared, and all outputs take their reset values. An in-flight set is discarded.

## Timing
- Reset values: ts_valid=0, ts_value=0, ts_channel=0, ts_hit=0, ts_last=0, busy=0.
- Edge to capture: the capture register is written at the clock edge that ends the detect-rise cycle. busy goes high on the following cycle.
- COLLECT to OUTPUT: ts_valid rises 1 cycle after the exit condition.
- Throughput: one word per cycle while ts_ready=1. A full set drains in CHANNELS cycles.
- IDLE re-entry: 1 cycle after the ts_last handshake. An edge in that IDLE cycle starts a new set.
- Dead time between sets equals the OUTPUT duration plus 1 cycle.
- Counter wrap inside the window is legal. Captured values are raw counter values, and wrap handling is modulo arithmetic downstream (or in relative mode below).

## Configuration
- TIMESTAMP_RELATIVE_EN defined: ts_value = (capture - t0) mod 2^TS_WIDTH, so the earliest channel(s) report 0. This is correct across counter wrap.
- Undefined: ts_value is the absolute counter value at capture.
- In both modes, a missed channel reports ts_hit=0 and ts_value=0.

## Test plan
- Reset, then detect=0 for 20 cycles: busy=0, ts_valid=0, cnt=20.
- Edges on ch0@cnt=100, ch2@103, ch1@110, ch3@150, with ts_ready=1:
  - Absolute mode: words (0,100,hit), (1,110), (2,103), (3,150,last). The exit is all-hit, with no wait for WINDOW.
  - Relative mode: words 0, 10, 3, 50.
- WINDOW=8, ch0@50, ch1@57, ch2@58, ch3 silent: ch1 is captured (last window cycle); ch2 and ch3 report ts_hit=0, ts_value=0.
- detect[0] held high for 200 cycles, then ch1–ch3 edges: ch0 is captured only once. After the set drains there is no new set until detect[0] falls and rises again.
- ts_ready toggled 1 cycle on / 2 cycles off: each word is held stable while stalled, there are 4 handshakes in order, and edges during OUTPUT are dropped.
- rst asserted mid-COLLECT after 2 captures: the next cycle shows busy=0 and cnt=0. The next set reports no stale hits.

Source files
------------

// File: rtl/multi_timestamp_capture.sv
// rtl/multi_timestamp_capture.sv - multi-channel first-edge timestamp capture with coincidence window
//
// One free-running counter is shared by CHANNELS detect inputs. The first rising
// edge on any channel opens a window of WINDOW cycles. Inside that window the
// first rising edge of each channel is timestamped. The completed set is then
// streamed out one channel per ts_valid/ts_ready handshake, in channel order.
//
// Optional feature: define TIMESTAMP_RELATIVE_EN to report timestamps relative
// to the first edge of the set (mod 2^TS_WIDTH) instead of raw counter values.
//
// Ports:
//   clk         sole clock
//   rst         synchronous active-high reset
//   detect      per-channel level flags; only rising edges count
//   ts_valid    output word valid
//   ts_ready    downstream accepts the word
//   ts_value    timestamp of ts_channel (0 when missed)
//   ts_channel  channel index of the current word
//   ts_hit      channel fired inside the window
//   ts_last     word for channel CHANNELS-1
//   busy        a set is being collected or streamed
module multi_timestamp_capture #(
  parameter int CHANNELS = 4,
  parameter int TS_WIDTH = 32,
  parameter int WINDOW   = 50000,
  localparam int CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] detect,
  output logic                ts_valid,
  input  logic                ts_ready,
  output logic [TS_WIDTH-1:0] ts_value,
  output logic [CH_W-1:0]     ts_channel,
  output logic                ts_hit,
  output logic                ts_last,
  output logic                busy
);

  localparam logic [TS_WIDTH-1:0] WIN = TS_WIDTH'(WINDOW);

  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_OUTPUT} state_t;

  state_t              state;
  logic [TS_WIDTH-1:0] cnt;
  logic [TS_WIDTH-1:0] wcnt;
  logic [CHANNELS-1:0] prev;
  logic [CHANNELS-1:0] hit;
  logic [TS_WIDTH-1:0] cap [CHANNELS];

`ifdef TIMESTAMP_RELATIVE_EN
  logic [TS_WIDTH-1:0] t0;
  logic [TS_WIDTH-1:0] t0_n;
`endif

  logic [CHANNELS-1:0] edge_det;
  logic [CHANNELS-1:0] hit_n;
  logic [TS_WIDTH-1:0] cap_n [CHANNELS];
  logic                all_hit_n;
  logic [TS_WIDTH-1:0] wcnt_inc;
  logic [CH_W-1:0]     nxt_ch;
  logic [TS_WIDTH-1:0] nxt_raw;
  logic                nxt_hit;
  logic [TS_WIDTH-1:0] nxt_val;
  logic [TS_WIDTH-1:0] first_val;

  assign edge_det = detect & ~prev;
  assign wcnt_inc = wcnt + TS_WIDTH'(1);
  assign nxt_ch   = ts_channel + CH_W'(1);

  // Next-state capture view: the word loaded on entry to OUTPUT must already
  // include captures made in the exit cycle itself.
  always_comb begin
    hit_n = hit;
    cap_n = cap;
    if (state == S_IDLE) begin
      for (int i = 0; i < CHANNELS; i++) begin
        hit_n[i] = edge_det[i];
        cap_n[i] = edge_det[i] ? cnt : '0;
      end
    end else if (state == S_COLLECT) begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (edge_det[i] && !hit[i]) begin
          hit_n[i] = 1'b1;
          cap_n[i] = cnt;
        end
      end
    end
    all_hit_n = &hit_n;

    nxt_raw = '0;
    nxt_hit = 1'b0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (CH_W'(i) == nxt_ch) begin
        nxt_raw = cap[i];
        nxt_hit = hit[i];
      end
    end

`ifdef TIMESTAMP_RELATIVE_EN
    t0_n      = (state == S_IDLE) ? cnt : t0;
    first_val = hit_n[0] ? (cap_n[0] - t0_n) : '0;
    nxt_val   = nxt_hit ? (nxt_raw - t0) : '0;
`else
    first_val = hit_n[0] ? cap_n[0] : '0;
    nxt_val   = nxt_hit ? nxt_raw : '0;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      cnt        <= '0;
      wcnt       <= '0;
      prev       <= '0;
      hit        <= '0;
      for (int i = 0; i < CHANNELS; i++) cap[i] <= '0;
`ifdef TIMESTAMP_RELATIVE_EN
      t0         <= '0;
`endif
      ts_valid   <= 1'b0;
      ts_value   <= '0;
      ts_channel <= '0;
      ts_hit     <= 1'b0;
      ts_last    <= 1'b0;
      busy       <= 1'b0;
    end else begin
      cnt  <= cnt + TS_WIDTH'(1);
      prev <= detect;
      hit  <= hit_n;
      cap  <= cap_n;
`ifdef TIMESTAMP_RELATIVE_EN
      t0   <= t0_n;
`endif
      case (state)
        S_IDLE: begin
          if (|edge_det) begin
            wcnt <= TS_WIDTH'(1);
            busy <= 1'b1;
            // A one-cycle window, or every channel firing at once, leaves
            // nothing more to collect.
            if (all_hit_n || (WINDOW == 1)) begin
              state      <= S_OUTPUT;
              ts_valid   <= 1'b1;
              ts_channel <= '0;
              ts_value   <= first_val;
              ts_hit     <= hit_n[0];
              ts_last    <= 1'b0;
            end else begin
              state <= S_COLLECT;
            end
          end
        end
        S_COLLECT: begin
          wcnt <= wcnt_inc;
          // wcnt_inc reaching WINDOW marks cycle t0+WINDOW-1, the last
          // capturable cycle; its edges are already folded into hit_n.
          if (all_hit_n || (wcnt_inc == WIN)) begin
            state      <= S_OUTPUT;
            ts_valid   <= 1'b1;
            ts_channel <= '0;
            ts_value   <= first_val;
            ts_hit     <= hit_n[0];
            ts_last    <= 1'b0;
          end
        end
        S_OUTPUT: begin
          if (ts_ready) begin
            if (ts_last) begin
              state      <= S_IDLE;
              ts_valid   <= 1'b0;
              ts_value   <= '0;
              ts_channel <= '0;
              ts_hit     <= 1'b0;
              ts_last    <= 1'b0;
              busy       <= 1'b0;
            end else begin
              ts_channel <= nxt_ch;
              ts_value   <= nxt_val;
              ts_hit     <= nxt_hit;
              ts_last    <= (nxt_ch == CH_W'(CHANNELS - 1));
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_multi_timestamp_capture.sv
// tb/tb_multi_timestamp_capture.sv - self-checking bench for multi_timestamp_capture
module tb_multi_timestamp_capture;

  localparam logic [15:0] NONE = 16'hFFFF;

  logic       clk;
  logic       rst;
  logic [3:0] detect;
  logic       ts_ready;

  logic        v0, h0, l0, b0;
  logic [1:0]  c0;
  logic [31:0] val0;
  logic        v1, h1, l1, b1;
  logic [1:0]  c1;
  logic [31:0] val1;

  multi_timestamp_capture #(.CHANNELS(4), .TS_WIDTH(32), .WINDOW(50000)) dut (
    .clk(clk), .rst(rst), .detect(detect),
    .ts_valid(v0), .ts_ready(ts_ready), .ts_value(val0),
    .ts_channel(c0), .ts_hit(h0), .ts_last(l0), .busy(b0)
  );

  multi_timestamp_capture #(.CHANNELS(4), .TS_WIDTH(32), .WINDOW(8)) dut_w (
    .clk(clk), .rst(rst), .detect(detect),
    .ts_valid(v1), .ts_ready(ts_ready), .ts_value(val1),
    .ts_channel(c1), .ts_hit(h1), .ts_last(l1), .busy(b1)
  );

  typedef struct packed {
    logic        valid;
    logic [1:0]  ch;
    logic [31:0] val;
    logic        hit;
    logic        last;
    logic        busy;
  } out_t;

  out_t o0, o1;
  assign o0 = {v0, c0, val0, h0, l0, b0};
  assign o1 = {v1, c1, val1, h1, l1, b1};

  // Detect level is high for r1<=cnt<f1 and r2<=cnt<f2; index [i] is channel i.
  typedef struct packed {
    logic [3:0][15:0] r1;
    logic [3:0][15:0] f1;
    logic [3:0][15:0] r2;
    logic [3:0][15:0] f2;
    logic             ready_mode;
    logic             sel;
    logic [3:0]       exp_hit;
    logic [3:0][31:0] exp_abs;
    logic [15:0]      t0;
    logic [15:0]      quiet_until;
    logic [15:0]      rearm_tc;
  } vec_t;

  int   n_checks;
  int   n_err;
  int   tc;
  int   tcnt;
  vec_t vecs[5];
  vec_t vr;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model of the free-running counter.
  always @(posedge clk) begin
    if (rst) tcnt <= 0;
    else     tcnt <= tcnt + 1;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cnt=%0d)", name, act, exp, tc);
    end
  endtask

  function automatic logic in_iv(input int t, input int r, input int f);
    return (t >= r) && (t < f);
  endfunction

  function automatic logic [31:0] ev(input vec_t v, input int i);
    if (!v.exp_hit[i]) return 32'd0;
`ifdef TIMESTAMP_RELATIVE_EN
    return v.exp_abs[i] - 32'(v.t0);
`else
    return v.exp_abs[i];
`endif
  endfunction

  task automatic do_rst();
    detect = '0;
    rst    = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst    = 1'b0;
  endtask

  task automatic run_set(input vec_t v, input string tag);
    int         idx;
    out_t       o;
    logic [3:0] d;
    idx = 0;
    do_rst();
    for (int k = 0; k < 400; k++) begin
      if (k > 0) @(negedge clk);
      tc = tcnt;
      for (int i = 0; i < 4; i++)
        d[i] = in_iv(tc, int'(v.r1[i]), int'(v.f1[i])) | in_iv(tc, int'(v.r2[i]), int'(v.f2[i]));
      detect   = d;
      ts_ready = v.ready_mode ? (tc % 3 == 0) : 1'b1;
      o = v.sel ? o1 : o0;
      if (tc == 0)
        chk({tag, "_reset"}, 64'({o.valid, o.ch, o.val, o.hit, o.last, o.busy}), 64'd0);
      if (tc == int'(v.t0))
        chk({tag, "_idle_before_edge"}, 64'(o.busy), 64'd0);
      if (tc == int'(v.t0) + 1)
        chk({tag, "_busy_after_edge"}, 64'(o.busy), 64'd1);
      if (o.valid) begin
        if (idx < 4)
          chk({tag, "_word"}, 64'({o.ch, o.hit, o.last, o.val}),
              64'({2'(idx), v.exp_hit[idx], (idx == 3), ev(v, idx)}));
        else
          chk({tag, "_extra_word"}, 64'(o.valid), 64'd0);
        if (ts_ready && idx < 4) idx++;
      end else if (idx == 4 && tc < int'(v.quiet_until)) begin
        chk({tag, "_quiet"}, 64'(o.busy), 64'd0);
      end
      if (tc == int'(v.rearm_tc))
        chk({tag, "_rearm"}, 64'(o.busy), 64'd1);
      if (idx == 4 && tc >= int'(v.quiet_until) && tc >= int'(v.rearm_tc)) break;
    end
    n_checks++;
    if (idx < 4) begin
      n_err++;
      $display("FAIL %s_timeout: got %0d words required 4", tag, idx);
    end
  endtask

  initial begin
    n_checks = 0;
    n_err    = 0;
    tc       = 0;
    rst      = 1'b1;
    detect   = '0;
    ts_ready = 1'b0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      vecs[i] = '0;
      vecs[i].r2 = {4{NONE}};
      vecs[i].f2 = {4{NONE}};
      vecs[i].rearm_tc = NONE;
    end

    // All channels rise together at cnt=20: straight to OUTPUT.
    vecs[0].r1 = {16'd20, 16'd20, 16'd20, 16'd20};
    vecs[0].f1 = {16'd23, 16'd23, 16'd23, 16'd23};
    vecs[0].exp_hit = 4'b1111;
    vecs[0].exp_abs = {32'd20, 32'd20, 32'd20, 32'd20};
    vecs[0].t0 = 16'd20;

    // ch0@100, ch2@103, ch1@110, ch3@150; all-hit exit.
    vecs[1].r1 = {16'd150, 16'd103, 16'd110, 16'd100};
    vecs[1].f1 = {16'd153, 16'd106, 16'd113, 16'd103};
    vecs[1].exp_hit = 4'b1111;
    vecs[1].exp_abs = {32'd150, 32'd103, 32'd110, 32'd100};
    vecs[1].t0 = 16'd100;

    // WINDOW=8: ch1@57 is the last capturable cycle, ch2@58 is missed.
    vecs[2].sel = 1'b1;
    vecs[2].r1 = {NONE, 16'd58, 16'd57, 16'd50};
    vecs[2].f1 = {NONE, 16'd61, 16'd60, 16'd53};
    vecs[2].exp_hit = 4'b0011;
    vecs[2].exp_abs = {32'd0, 32'd0, 32'd57, 32'd50};
    vecs[2].t0 = 16'd50;

    // Stalled drain (ready 1 on / 2 off) with fresh edges during OUTPUT.
    vecs[3].ready_mode = 1'b1;
    vecs[3].r1 = {16'd33, 16'd32, 16'd31, 16'd30};
    vecs[3].f1 = {16'd36, 16'd35, 16'd34, 16'd33};
    vecs[3].r2 = {NONE, NONE, 16'd36, 16'd40};
    vecs[3].f2 = {NONE, NONE, 16'd39, 16'd43};
    vecs[3].exp_hit = 4'b1111;
    vecs[3].exp_abs = {32'd33, 32'd32, 32'd31, 32'd30};
    vecs[3].t0 = 16'd30;
    vecs[3].quiet_until = 16'd60;

    // detect[0] held 10..209: captured once, no new set until it re-rises at 215.
    vecs[4].r1 = {16'd40, 16'd30, 16'd20, 16'd10};
    vecs[4].f1 = {16'd43, 16'd33, 16'd23, 16'd210};
    vecs[4].r2 = {NONE, NONE, NONE, 16'd215};
    vecs[4].f2 = {NONE, NONE, NONE, 16'd220};
    vecs[4].exp_hit = 4'b1111;
    vecs[4].exp_abs = {32'd40, 32'd30, 32'd20, 32'd10};
    vecs[4].t0 = 16'd10;
    vecs[4].quiet_until = 16'd210;
    vecs[4].rearm_tc = 16'd216;

    for (int i = 0; i < 5; i++) run_set(vecs[i], $sformatf("vec%0d", i));

    // Reset mid-COLLECT (WINDOW=8 instance) after ch0@10 and ch1@12 captures.
    do_rst();
    for (int k = 0; k < 20; k++) begin
      if (k > 0) @(negedge clk);
      tc = tcnt;
      if (tc == 15) break;
      detect   = {2'b00, in_iv(tc, 12, 15), in_iv(tc, 10, 13)};
      ts_ready = 1'b1;
      if (tc == 14) chk("rst_seq_collecting", 64'(o1.busy), 64'd1);
    end
    vr = '0;
    vr.sel = 1'b1;
    vr.r1 = {16'd6, 16'd5, NONE, NONE};
    vr.f1 = {16'd9, 16'd8, NONE, NONE};
    vr.r2 = {4{NONE}};
    vr.f2 = {4{NONE}};
    vr.exp_hit = 4'b1100;
    vr.exp_abs = {32'd6, 32'd5, 32'd0, 32'd0};
    vr.t0 = 16'd5;
    vr.rearm_tc = NONE;
    run_set(vr, "rst_seq");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
